text_buffer_arbiter: RTL and testbench
======================================

// Module: text_buffer_arbiter
// PURPOSE
//  Owns the single-port character RAM that feeds the text renderer's font ROM lookup.
//  Shares the RAM between two requesters: display fetches from the renderer and
//  character writes from the calculator stack logic.
//  Also sequences a full-screen clear.
//  Display reads always win; writes and clear use the free cycles.
// PARAMETERS
//  COLS      32     text columns (x[7:3] range)
//  ROWS      4      text rows (y[5:4] range)
//  ADDR_W    7      cell address width; cell = row*COLS+col; COLS*ROWS <= 2**ADDR_W
//  CHAR_W    7      character code width (font ROM char_addr width)
//  CLR_CHAR  7'h20  code written to every cell by a clear
// PORTS
//  clk        in   1       system/pixel clock
//  reset      in   1       asynchronous, active-low reset
//  disp_req   in   1       renderer fetch strobe, at most 1 per 2 cycles
//  disp_addr  in   ADDR_W  cell to fetch
//  disp_char  out  CHAR_W  fetched code, registered
//  disp_valid out  1       disp_char valid strobe
//  wr_valid   in   1       write request
//  wr_ready   out  1       write accepted when wr_valid&wr_ready at posedge
//  wr_addr    in   ADDR_W  cell to write
//  wr_char    in   CHAR_W  code to write
//  wr_err     out  1       1-cycle pulse: accepted write had wr_addr >= COLS*ROWS, discarded
//  clr_start  in   1       clear request pulse
//  clr_busy   out  1       clear pending or in progress
//  ram_addr   out  ADDR_W  RAM address
//  ram_we     out  1       RAM write enable
//  ram_wdata  out  CHAR_W  RAM write data
//  ram_rdata  in   CHAR_W  RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  Reset (reset=0, async) values:
//   - disp_char=0, disp_valid=0, wr_err=0, clr_busy=0, ram_we=0, ram_addr=0
//   - hold register empty; state IDLE
//   - wr_ready=1 in the first cycle after reset release
//  Reset mid-clear or mid-write aborts the operation. RAM contents are undefined-but-unchanged by the arbiter.
//  Write path:
//   - one-entry hold register
//   - wr_ready = hold empty & ~clr_busy
//   - an accepted write fills hold on that edge
//   - out-of-range address: accepted, not held, wr_err pulses next cycle
//  Per-cycle RAM grant priority:
//   1. disp_req: ram_addr=disp_addr, ram_we=0
//   2. CLEAR sweep: ram_addr=clr_cnt, ram_we=1, ram_wdata=CLR_CHAR
//   3. hold full and state IDLE: ram_addr=hold addr, ram_we=1; hold empties on that edge
//   4. otherwise: ram_we=0, ram_addr holds its previous value
//  Display latency:
//   - disp_req in cycle N gives ram_rdata at N+1
//   - disp_char=ram_rdata and disp_valid=1 at N+2, for 1 cycle
//   - display is never stalled; back-to-back requests are pipelined
//  State machine:
//   - IDLE: clr_start sets clr_pending (clr_busy=1 next cycle)
//     - IDLE->CLEAR when clr_pending & hold empty; clr_cnt=0
//   - CLEAR: clr_cnt increments only on granted cycles (no disp_req)
//     - CLEAR->IDLE after the write of cell COLS*ROWS-1; clr_busy falls the cycle after
//   - clr_start while clr_busy=1 is ignored
//  Ordering:
//   - a write accepted before clr_start lands in RAM before the sweep begins and is then cleared
//   - no write is accepted while clr_busy=1
//  Same-cycle events:
//   - wr_valid and clr_start together with wr_ready=1: write accepted, clear pends behind it
//   - write to the cell being fetched in the same cycle: fetch returns old data
// TESTING
//  1. Reset: drive reset=0 mid-traffic -> all outputs at reset values immediately; wr_ready=1 after release.
//  2. Write then read:
//     - write addr 5 = 7'h41, then disp_req addr 5 with 3 idle cycles between
//     - expect disp_valid at req+2 with disp_char=7'h41
//  3. Contention:
//     - disp_req every cycle for 10 cycles while wr_valid held with addr 3
//     - expect ram_we=0 throughout and wr_ready=0 after the first accept
//     - expect the write to land in the first cycle without disp_req
//  4. Clear with fetches every 2nd cycle:
//     - clr_start -> exactly 128 ram_we cycles with CLR_CHAR, addrs 0..127 in order
//     - clr_busy falls after addr 127; a later fetch of any cell returns 7'h20
//  5. Clear ordering:
//     - wr_valid (addr 9, 7'h33) and clr_start in the same cycle
//     - expect write landed, then cleared: cell 9 = 7'h20; wr_ready=0 until clr_busy=0
//  6. Error handling:
//     - write addr 7'd127 with COLS=32, ROWS=2 -> wr_err pulse, ram_we stays 0
//     - second clr_start during clear ignored: the sweep runs once only

Source files
------------

// File: rtl/text_buffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : text_buffer_arbiter_if
// Brief   : Display-fetch, write, clear and RAM signal bundle for the arbiter.
// Revision: 1.0
// ============================================================================
interface text_buffer_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int CHAR_W = 7
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [CHAR_W-1:0] disp_char;
    logic              disp_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [CHAR_W-1:0] wr_char;
    logic              wr_err;
    logic              clr_start;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [CHAR_W-1:0] ram_wdata;
    logic [CHAR_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_char, clr_start, ram_rdata,
        output disp_char, disp_valid, wr_ready, wr_err, clr_busy, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_char, clr_start, ram_rdata,
        input  disp_char, disp_valid, wr_ready, wr_err, clr_busy, ram_addr, ram_we, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/text_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : text_buffer_arbiter
// Brief   : Shares the character RAM between display fetches, held writes
//           and a full-screen clear sweep; display always wins.
// Revision: 1.0
// ============================================================================
module text_buffer_arbiter #(
    parameter int              COLS     = 32,
    parameter int              ROWS     = 4,
    parameter int              ADDR_W   = 7,
    parameter int              CHAR_W   = 7,
    parameter logic [CHAR_W-1:0] CLR_CHAR = 7'h20
) (
    input  wire logic           clk,
    input  wire logic           reset,
    text_buffer_arbiter_if.slave bus
);

    localparam int                c_cells     = COLS * ROWS;
    localparam logic [ADDR_W:0]   c_cells_w   = (ADDR_W + 1)'(c_cells);
    localparam logic [ADDR_W-1:0] c_last_cell = ADDR_W'(c_cells - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_clr_pending;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_hold_full;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [CHAR_W-1:0] r_hold_char;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_wr_err;
    logic              r_disp_p1;
    logic              r_disp_valid;
    logic [CHAR_W-1:0] r_disp_char;

    logic              w_clr_busy;
    logic              w_wr_ready;
    logic              w_wr_accept;
    logic              w_wr_in_range;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [CHAR_W-1:0] w_ram_wdata;
    logic              w_clr_grant;
    logic              w_hold_drain;

    assign w_clr_busy    = r_clr_pending | (r_state == ST_CLEAR);
    assign w_wr_ready    = ~r_hold_full & ~w_clr_busy;
    assign w_wr_accept   = bus.wr_valid & w_wr_ready;
    assign w_wr_in_range = ({1'b0, bus.wr_addr} < c_cells_w);

    always_comb begin
        w_state_nxt  = r_state;
        w_ram_addr   = r_last_addr;
        w_ram_we     = 1'b0;
        w_ram_wdata  = r_hold_char;
        w_clr_grant  = 1'b0;
        w_hold_drain = 1'b0;

        if (bus.disp_req) begin
            w_ram_addr = bus.disp_addr;
        end else if (r_state == ST_CLEAR) begin
            w_ram_addr  = r_clr_cnt;
            w_ram_we    = 1'b1;
            w_ram_wdata = CLR_CHAR;
            w_clr_grant = 1'b1;
        end else if (r_hold_full) begin
            w_ram_addr   = r_hold_addr;
            w_ram_we     = 1'b1;
            w_hold_drain = 1'b1;
        end

        case (r_state)
            // A pending clear waits for the held write so that write is swept too
            ST_IDLE:  if (r_clr_pending && !r_hold_full) w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_clr_grant && (r_clr_cnt == c_last_cell)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_clr_pending <= 1'b0;
            r_clr_cnt     <= '0;
            r_hold_full   <= 1'b0;
            r_hold_addr   <= '0;
            r_hold_char   <= '0;
            r_last_addr   <= '0;
            r_wr_err      <= 1'b0;
            r_disp_p1     <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_disp_char   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_addr <= w_ram_addr;

            if (bus.clr_start && !w_clr_busy) begin
                r_clr_pending <= 1'b1;
            end
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_CLEAR)) begin
                r_clr_pending <= 1'b0;
                r_clr_cnt     <= '0;
            end else if (w_clr_grant) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end

            if (w_hold_drain) begin
                r_hold_full <= 1'b0;
            end
            if (w_wr_accept && w_wr_in_range) begin
                r_hold_full <= 1'b1;
                r_hold_addr <= bus.wr_addr;
                r_hold_char <= bus.wr_char;
            end
            r_wr_err <= w_wr_accept & ~w_wr_in_range;

            r_disp_p1    <= bus.disp_req;
            r_disp_valid <= r_disp_p1;
            if (r_disp_p1) begin
                r_disp_char <= bus.ram_rdata;
            end
        end
    end

    // RAM strobes are forced idle while reset is held, even if a fetch is requested
    assign bus.ram_we     = w_ram_we & reset;
    assign bus.ram_addr   = reset ? w_ram_addr : '0;
    assign bus.ram_wdata  = w_ram_wdata;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.wr_err     = r_wr_err;
    assign bus.clr_busy   = w_clr_busy;
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_char  = r_disp_char;

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_text_buffer_arbiter
// Brief   : Directed and randomized checks of text_buffer_arbiter against a RAM
//           model and an expected-contents array.
// Revision: 1.0
// ============================================================================
module tb_text_buffer_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_buffer_arbiter_if #(.ADDR_W(7), .CHAR_W(7)) bi ();
    text_buffer_arbiter_if #(.ADDR_W(7), .CHAR_W(7)) bi2 ();

    text_buffer_arbiter #(.COLS(32), .ROWS(4), .ADDR_W(7), .CHAR_W(7), .CLR_CHAR(7'h20)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi)
    );

    text_buffer_arbiter #(.COLS(32), .ROWS(2), .ADDR_W(7), .CHAR_W(7), .CLR_CHAR(7'h20)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bi2)
    );

    // Environment RAM: synchronous, read-before-write
    logic [6:0] mem [128] = '{default: 7'h00};
    always @(posedge clk) begin
        if (bi.ram_we) mem[bi.ram_addr] <= bi.ram_wdata;
        bi.ram_rdata <= mem[bi.ram_addr];
    end
    assign bi2.ram_rdata = '0;

    logic [6:0] exp_mem [128];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each fetch must return the RAM cell as it stood when requested, two cycles later
    typedef struct {
        logic [6:0] ch;
        int         stamp;
    } fetch_t;
    fetch_t fq[$];

    always @(negedge clk) begin : m_mon
        fetch_t f;
        if (!reset) begin
            fq.delete();
        end else begin
            if (bi.disp_valid) begin
                if (fq.size() == 0) begin
                    chk("disp_spurious", 32'd1, 32'd0);
                end else begin
                    f = fq.pop_front();
                    chk("disp_char", 32'(bi.disp_char), 32'(f.ch));
                    chk("disp_latency", 32'(cyc - f.stamp), 32'd2);
                end
            end
            if (bi.disp_req) begin
                chk("we_during_disp", 32'(bi.ram_we), 32'd0);
                fq.push_back('{mem[bi.disp_addr], cyc});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bi.disp_req   = 1'b0; bi.disp_addr = '0; bi.wr_valid = 1'b0;
        bi.wr_addr    = '0;   bi.wr_char   = '0; bi.clr_start = 1'b0;
        bi2.disp_req  = 1'b0; bi2.disp_addr = '0; bi2.wr_valid = 1'b0;
        bi2.wr_addr   = '0;   bi2.wr_char   = '0; bi2.clr_start = 1'b0;
    endtask

    task automatic fetch_expect(input logic [6:0] addr, input logic [6:0] exp, input string tag);
        bi.disp_req  = 1'b1;
        bi.disp_addr = addr;
        tick();
        bi.disp_req  = 1'b0;
        tick();
        chk({tag, "_valid"}, 32'(bi.disp_valid), 32'd1);
        chk({tag, "_char"}, 32'(bi.disp_char), 32'(exp));
    endtask

    initial begin
        int         n_we;
        int         last_c;
        int         c;
        logic       prev_req;
        logic [6:0] wdat;

        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_disp_valid", 32'(bi.disp_valid), 32'd0);
        chk("rst_disp_char", 32'(bi.disp_char), 32'd0);
        chk("rst_wr_err", 32'(bi.wr_err), 32'd0);
        chk("rst_clr_busy", 32'(bi.clr_busy), 32'd0);
        chk("rst_ram_we", 32'(bi.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bi.ram_addr), 32'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("rst_wr_ready", 32'(bi.wr_ready), 32'd1);

        // Write then read back
        bi.wr_valid = 1'b1; bi.wr_addr = 7'd5; bi.wr_char = 7'h41;
        #1 chk("t2_ready", 32'(bi.wr_ready), 32'd1);
        tick();
        idle();
        #1;
        chk("t2_we", 32'(bi.ram_we), 32'd1);
        chk("t2_waddr", 32'(bi.ram_addr), 32'd5);
        chk("t2_wdata", 32'(bi.ram_wdata), 32'h41);
        tick();
        repeat (3) tick();
        fetch_expect(7'd5, 7'h41, "t2_fetch");
        tick();
        chk("t2_valid_pulse", 32'(bi.disp_valid), 32'd0);

        // Contention: fetches every cycle starve the held write
        wdat = 7'($urandom);
        for (int i = 0; i < 10; i++) begin
            bi.disp_req = 1'b1; bi.disp_addr = 7'($urandom_range(0, 127));
            bi.wr_valid = 1'b1; bi.wr_addr = 7'd3; bi.wr_char = wdat;
            #1;
            chk("t3_we_low", 32'(bi.ram_we), 32'd0);
            chk("t3_ready", 32'(bi.wr_ready), (i == 0) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        #1;
        chk("t3_land_we", 32'(bi.ram_we), 32'd1);
        chk("t3_land_addr", 32'(bi.ram_addr), 32'd3);
        chk("t3_land_data", 32'(bi.ram_wdata), 32'(wdat));
        repeat (3) tick();

        // Reset in the middle of a held write plus a pending clear
        bi.wr_valid = 1'b1; bi.wr_addr = 7'd10; bi.wr_char = 7'h77; bi.clr_start = 1'b1;
        tick();
        bi.wr_valid = 1'b0; bi.clr_start = 1'b0; bi.disp_req = 1'b1; bi.disp_addr = 7'd2;
        tick();
        tick();
        chk("t1_busy_before", 32'(bi.clr_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t1_disp_valid", 32'(bi.disp_valid), 32'd0);
        chk("t1_disp_char", 32'(bi.disp_char), 32'd0);
        chk("t1_wr_err", 32'(bi.wr_err), 32'd0);
        chk("t1_clr_busy", 32'(bi.clr_busy), 32'd0);
        chk("t1_ram_we", 32'(bi.ram_we), 32'd0);
        chk("t1_ram_addr", 32'(bi.ram_addr), 32'd0);
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("t1_ready_after", 32'(bi.wr_ready), 32'd1);
        chk("t1_no_write", 32'(bi.ram_we), 32'd0);
        chk("t1_busy_after", 32'(bi.clr_busy), 32'd0);

        // Clear sweep with fetches every second cycle
        bi.clr_start = 1'b1;
        tick();
        bi.clr_start = 1'b0;
        #1 chk("t4_busy", 32'(bi.clr_busy), 32'd1);
        n_we = 0; last_c = 0; c = 0;
        while (c < 400 && bi.clr_busy) begin
            bi.disp_req  = (c[0] == 1'b0);
            bi.disp_addr = 7'($urandom_range(0, 127));
            #1;
            chk("t4_ready_low", 32'(bi.wr_ready), 32'd0);
            if (bi.ram_we) begin
                chk("t4_addr", 32'(bi.ram_addr), 32'(n_we));
                chk("t4_data", 32'(bi.ram_wdata), 32'h20);
                n_we++;
                last_c = c;
            end
            c++;
            tick();
        end
        idle();
        chk("t4_count", 32'(n_we), 32'd128);
        chk("t4_busy_fall", 32'(c - last_c), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) fetch_expect(7'($urandom_range(0, 127)), 7'h20, "t4_fetch");

        // Write and clear requested together: write lands first, then gets swept
        bi.wr_valid = 1'b1; bi.wr_addr = 7'd9; bi.wr_char = 7'h33; bi.clr_start = 1'b1;
        #1 chk("t5_ready", 32'(bi.wr_ready), 32'd1);
        tick();
        idle();
        n_we = 0; c = 0;
        while (c < 400 && bi.clr_busy) begin
            bi.wr_valid = 1'b1; bi.wr_addr = 7'd11; bi.wr_char = 7'h55;
            #1;
            chk("t5_ready_low", 32'(bi.wr_ready), 32'd0);
            if (bi.ram_we) begin
                if (n_we == 0) begin
                    chk("t5_first_addr", 32'(bi.ram_addr), 32'd9);
                    chk("t5_first_data", 32'(bi.ram_wdata), 32'h33);
                end
                n_we++;
            end
            c++;
            tick();
        end
        idle();
        chk("t5_count", 32'(n_we), 32'd129);
        #1 chk("t5_ready_after", 32'(bi.wr_ready), 32'd1);
        tick();
        fetch_expect(7'd9, 7'h20, "t5_cell9");
        fetch_expect(7'd11, 7'h20, "t5_cell11");

        // Out-of-range writes on the 64-cell instance
        bi2.wr_valid = 1'b1; bi2.wr_addr = 7'd127; bi2.wr_char = 7'h12;
        #1 chk("t6_ready", 32'(bi2.wr_ready), 32'd1);
        tick();
        idle();
        #1;
        chk("t6_err", 32'(bi2.wr_err), 32'd1);
        chk("t6_we", 32'(bi2.ram_we), 32'd0);
        tick();
        chk("t6_err_pulse", 32'(bi2.wr_err), 32'd0);
        chk("t6_we2", 32'(bi2.ram_we), 32'd0);
        chk("t6_ready2", 32'(bi2.wr_ready), 32'd1);
        bi2.wr_valid = 1'b1; bi2.wr_addr = 7'd63; bi2.wr_char = 7'h4A;
        tick();
        idle();
        #1;
        chk("t6_in_err", 32'(bi2.wr_err), 32'd0);
        chk("t6_in_we", 32'(bi2.ram_we), 32'd1);
        chk("t6_in_addr", 32'(bi2.ram_addr), 32'd63);
        tick();
        bi2.wr_valid = 1'b1; bi2.wr_addr = 7'd64; bi2.wr_char = 7'h4B;
        tick();
        idle();
        #1;
        chk("t6_edge_err", 32'(bi2.wr_err), 32'd1);
        chk("t6_edge_we", 32'(bi2.ram_we), 32'd0);
        tick();

        // Repeated clr_start during a sweep is ignored
        bi.clr_start = 1'b1;
        tick();
        bi.clr_start = 1'b0;
        n_we = 0; c = 0;
        while (c < 400 && bi.clr_busy) begin
            bi.clr_start = (c == 5) || (c == 50);
            #1;
            if (bi.ram_we) n_we++;
            c++;
            tick();
        end
        idle();
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bi.ram_we) n_we++;
            tick();
        end
        chk("t6_sweep_once", 32'(n_we), 32'd128);
        chk("t6_busy_end", 32'(bi.clr_busy), 32'd0);

        // Randomized traffic against expected final contents
        for (int a = 0; a < 128; a++) exp_mem[a] = 7'h20;
        prev_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bi.disp_req  = !prev_req && ($urandom_range(0, 1) == 1);
            bi.disp_addr = 7'($urandom_range(0, 127));
            bi.wr_valid  = ($urandom_range(0, 2) != 0);
            bi.wr_addr   = 7'($urandom_range(0, 127));
            bi.wr_char   = 7'($urandom);
            #1;
            if (bi.wr_valid && bi.wr_ready) exp_mem[bi.wr_addr] = bi.wr_char;
            prev_req = bi.disp_req;
            tick();
        end
        idle();
        repeat (4) tick();
        for (int a = 0; a < 128; a++) chk("rnd_cell", 32'(mem[a]), 32'(exp_mem[a]));
        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
